button_reader: RTL and testbench
================================

# button_reader

Debounced pushbutton input block for the feather board: the input-side counterpart to the LED blink path. Samples the raw active-low button pin `nBTN`, synchronises and debounces it, then produces a clean level plus single-cycle press, release, short-press and long-press event pulses. User-interface logic consumes these pulses directly, for example to select blink rates, with no further filtering.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz); must be ≥ 1.
- `LONG_CYCLES`, default 12000000: cycles of debounced hold before a long press is declared (1 s at 12 MHz); must be ≥ 1.
- `REPEAT_CYCLES`, default 2400000: auto-repeat period after a long press. Used only with `BUTTON_REPEAT_EN`; must be ≥ 1.
- `clk` input 1: single system clock; every flop is on its rising edge.
- `nRst` input 1: asynchronous, active-low reset.
- `nBTN` input 1: raw button pin, asynchronous to `clk`, low = pressed.
- `pressed` output 1: debounced level, 1 = held.
- `pressPulse` output 1: one-cycle pulse on debounced press.
- `releasePulse` output 1: one-cycle pulse on debounced release.
- `shortPress` output 1: one-cycle pulse on release when no long press was declared.
- `longPress` output 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeatPulse` output 1: one-cycle auto-repeat pulse. Tied to 0 without `BUTTON_REPEAT_EN`.

## Operation
- Synchroniser:
  - 2-flop chain on `nBTN`; both flops reset to 1 (released).
  - The synchronised value is inverted to `btnS` (1 = pressed).
- Debouncer:
  - Counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Clears whenever `btnS` equals the debounced level.
  - Increments while `btnS` differs from the debounced level.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - Any bounce back restarts the count from 0.
- FSM states:
  - IDLE: `pressed`=0. Goes to HELD on debounced rise; `pressPulse` fires and the hold counter clears to 0.
  - HELD: the hold counter increments each cycle.
    - Hold counter reaches `LONG_CYCLES`: go to LONG, pulse `longPress`.
    - Debounced fall first: go to IDLE, pulse `releasePulse` and `shortPress` together.
  - LONG: the hold counter saturates and never wraps. On debounced fall, go to IDLE and pulse `releasePulse` only.
- Hold counter width is `$clog2(LONG_CYCLES+1)`. The repeat counter width is `$clog2(REPEAT_CYCLES+1)`.
- Event pulses are mutually exclusive within a cycle, except `releasePulse`+`shortPress`, which fire together.

## Timing
- Reset values:
  - All outputs 0.
  - Sync flops 1.
  - FSM in IDLE.
  - All counters 0.
- Reset may occur mid-operation. Asserting `nRst` aborts immediately with no pulses. After release, a still-held button is re-detected as a fresh press.
- Press latency: `pressed` and `pressPulse` assert 2 + `DEBOUNCE_CYCLES` cycles after the first clk edge that samples `nBTN` low, given a stable input.
- Release latency is symmetric.
- `longPress` asserts exactly `LONG_CYCLES` cycles after `pressPulse`.
- All outputs are registered, with no combinational path from `nBTN`.

## Configuration
- `BUTTON_REPEAT_EN` defined:
  - In LONG, a repeat counter runs. `repeatPulse` fires every `REPEAT_CYCLES` cycles, first at `REPEAT_CYCLES` after `longPress`.
  - The counter clears on release or reset.
- `BUTTON_REPEAT_EN` undefined:
  - The repeat counter is absent.
  - `repeatPulse` is constant 0.

## Structure
- Shared package `button_pkg`:
  - FSM state typedef (IDLE, HELD, LONG).
  - Default cycle-count constants for 12 MHz.
- Sub-module `debounce`:
  - Contains the synchroniser and debounce counter.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `nRst`, `nIn`, `level`, `rise`, `fall`.
- `button_reader` contains the FSM, hold counter and repeat logic.

## Test plan
Parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=8. Cycle 0 is the first edge that samples `nBTN` low.
- Clean press held 10 cycles:
  - `pressed`/`pressPulse` at cycle 6.
  - Release sampled at cycle 10 gives `releasePulse`+`shortPress` at cycle 16.
  - No `longPress`.
- Bounce: `nBTN` low 3 cycles, high 1 cycle, then stable low from cycle 4 -> exactly one `pressPulse`, at cycle 10.
- Glitch: `nBTN` low for 3 cycles only -> no output ever changes.
- Hold for 40 cycles:
  - `longPress` at cycle 26.
  - Release produces `releasePulse` without `shortPress`.
  - `pressed` stays high throughout the hold.
- With `BUTTON_REPEAT_EN`, hold for 50 cycles -> `repeatPulse` at cycles 34, 42, 50 and beyond while held; none after release. Without the macro, `repeatPulse` stays 0.
- Reset mid-hold: `nRst` low at cycle 15 with the button held:
  - All outputs go to 0 immediately.
  - After `nRst` deasserts, `pressPulse` recurs 6 cycles later and the long-press timing restarts from it.

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM state type and default 12 MHz timing constants
//
// Purpose: common definitions for button_reader and its debounce sub-module.
// Ports: none (package).
package button_pkg;

  // Press-tracking FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  // Default cycle counts for a 12 MHz system clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;    // 10 ms
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 2400000;   // 200 ms

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - two-flop synchroniser and counter debouncer for an active-low pin
//
// Purpose: brings the raw active-low input into the clk domain and only accepts
// a level change once it has been stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk   in  system clock
//   nRst  in  asynchronous active-low reset
//   nIn   in  raw input, asynchronous, low = active
//   level out debounced level, 1 = active
//   rise  out one-cycle pulse, coincident with level going 1
//   fall  out one-cycle pulse, coincident with level going 0
module debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic nRst,
  input  logic nIn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The toggle happens on the edge that would take the count to
  // DEBOUNCE_CYCLES, so the stable run spans exactly DEBOUNCE_CYCLES samples.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          w_btn_s;

  // Synchronised and inverted: 1 = active.
  assign w_btn_s = ~r_sync2;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= nIn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (w_btn_s == r_level) begin
        // Agreement (including any bounce back) restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= w_btn_s;
        r_rise  <= w_btn_s;
        r_fall  <= ~w_btn_s;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced pushbutton reader with press/release/short/long/repeat events
//
// Purpose: turns the raw active-low button pin into a clean level plus
// single-cycle event pulses for user-interface logic.
// Optional feature macro: BUTTON_REPEAT_EN (auto-repeat while long-held).
// Ports:
//   clk          in  system clock
//   nRst         in  asynchronous active-low reset
//   nBTN         in  raw button pin, asynchronous, low = pressed
//   pressed      out debounced level, 1 = held
//   pressPulse   out one-cycle pulse on debounced press
//   releasePulse out one-cycle pulse on debounced release
//   shortPress   out one-cycle pulse on release with no long press declared
//   longPress    out one-cycle pulse when the hold reaches LONG_CYCLES
//   repeatPulse  out one-cycle auto-repeat pulse (0 without BUTTON_REPEAT_EN)
module button_reader
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic nRst,
  input  logic nBTN,
  output logic pressed,
  output logic pressPulse,
  output logic releasePulse,
  output logic shortPress,
  output logic longPress,
  output logic repeatPulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("LONG_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end

  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          w_level;
  logic          w_rise;
  logic          w_fall;

  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic [HW-1:0] r_hold;

  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_short_nxt;
  logic          w_long_nxt;

  logic          r_pressed;
  logic          r_press_pulse;
  logic          r_release_pulse;
  logic          r_short_press;
  logic          r_long_press;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .nRst (nRst),
    .nIn  (nBTN),
    .level(w_level),
    .rise (w_rise),
    .fall (w_fall)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state         <= IDLE;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_press   <= 1'b0;
      r_long_press    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pressed       <= w_level;
      r_press_pulse   <= w_press_nxt;
      r_release_pulse <= w_release_nxt;
      r_short_press   <= w_short_nxt;
      r_long_press    <= w_long_nxt;
    end
  end

  // Next-state logic. A release always wins over the long-press threshold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = HELD;
      end
      HELD: begin
        if (w_fall)                  w_state_nxt = IDLE;
        else if (r_hold == HOLD_LAST) w_state_nxt = LONG;
      end
      LONG: begin
        if (w_fall) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Event decode from the transition being taken this cycle.
  always_comb begin
    w_press_nxt   = (r_state == IDLE) && (w_state_nxt == HELD);
    w_release_nxt = (r_state != IDLE) && (w_state_nxt == IDLE);
    w_short_nxt   = (r_state == HELD) && (w_state_nxt == IDLE);
    w_long_nxt    = (r_state == HELD) && (w_state_nxt == LONG);
  end

  // Hold counter: zero in IDLE and on the press edge, counts in HELD,
  // saturates at LONG_CYCLES in LONG.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_hold <= '0;
    end else if (r_state == IDLE || w_state_nxt == IDLE) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HW'(1);
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_repeat;
  logic          w_rep_hit;

  // Only counts while staying in LONG; the entry cycle leaves it at 0 so the
  // first repeat lands REPEAT_CYCLES after longPress.
  assign w_rep_hit = (r_state == LONG) && (w_state_nxt == LONG) &&
                     (r_rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= w_rep_hit;
      if (r_state != LONG || w_state_nxt != LONG || w_rep_hit) begin
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign repeatPulse = r_repeat;
`else
  assign repeatPulse = 1'b0;
`endif

  assign pressed      = r_pressed;
  assign pressPulse   = r_press_pulse;
  assign releasePulse = r_release_pulse;
  assign shortPress   = r_short_press;
  assign longPress    = r_long_press;

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - scoreboard testbench for button_reader
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_REP   = 5'b00001;

  typedef struct {
    int         edge_no;
    logic [4:0] ev;
  } ev_t;

  typedef struct {
    int   edge_no;
    logic lvl;
  } lvl_t;

  logic clk = 1'b0;
  logic nRst;
  logic nBTN;
  logic pressed;
  logic pressPulse;
  logic releasePulse;
  logic shortPress;
  logic longPress;
  logic repeatPulse;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];

  int   edge_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic exp_pressed = 1'b0;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .nBTN        (nBTN),
    .pressed     (pressed),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .shortPress  (shortPress),
    .longPress   (longPress),
    .repeatPulse (repeatPulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Scoreboard: every cycle the observed event vector and level are compared
  // against the entry scheduled for this edge (or quiet / last level).
  always @(negedge clk) begin
    logic [4:0] obs;
    logic [4:0] exp_ev;
    if (mon_en) begin
      obs    = {pressPulse, releasePulse, shortPress, longPress, repeatPulse};
      exp_ev = '0;
      if (lvl_q.size() > 0 && lvl_q[0].edge_no == edge_n) begin
        exp_pressed = lvl_q[0].lvl;
        void'(lvl_q.pop_front());
      end
      if (ev_q.size() > 0 && ev_q[0].edge_no == edge_n) begin
        exp_ev = ev_q[0].ev;
        void'(ev_q.pop_front());
      end
      n_checks++;
      if (obs !== exp_ev)
        $display("FAIL events @edge %0d: got %b expected %b (press,rel,short,long,rep)", edge_n, obs, exp_ev);
      else
        n_pass++;
      n_checks++;
      if (pressed !== exp_pressed)
        $display("FAIL pressed @edge %0d: got %b expected %b", edge_n, pressed, exp_pressed);
      else
        n_pass++;
    end
  end

  task automatic start_seq(output int base);
    @(posedge clk);
    #2;
    base = edge_n + 1;
  endtask

  // Hold nBTN at v for n sampling edges.
  task automatic drive(input logic v, input int n);
    nBTN = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_ev(input int e, input logic [4:0] v);
    ev_t t;
    t.edge_no = e;
    t.ev = v;
    ev_q.push_back(t);
  endtask

  task automatic push_lvl(input int e, input logic v);
    lvl_t t;
    t.edge_no = e;
    t.lvl = v;
    lvl_q.push_back(t);
  endtask

  task automatic test_reset;
    logic [5:0] outs;
    nRst = 1'b0;
    nBTN = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    outs = {pressed, pressPulse, releasePulse, shortPress, longPress, repeatPulse};
    n_checks++;
    if (outs !== 6'b0) $display("FAIL reset_outputs: got %b expected 000000", outs);
    else n_pass++;
    nRst = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 8);
  endtask

  task automatic test_clean_press;
    int b;
    start_seq(b);
    push_ev(b + 6, EV_PRESS);
    push_ev(b + 16, EV_REL | EV_SHORT);
    push_lvl(b + 6, 1'b1);
    push_lvl(b + 16, 1'b0);
    drive(1'b0, 10);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL clean_press_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_min_press;
    int b;
    start_seq(b);
    push_ev(b + 6, EV_PRESS);
    push_ev(b + 10, EV_REL | EV_SHORT);
    push_lvl(b + 6, 1'b1);
    push_lvl(b + 10, 1'b0);
    drive(1'b0, D);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL min_press_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_glitch;
    int b;
    start_seq(b);
    drive(1'b0, D - 1);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL glitch_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce;
    int b;
    start_seq(b);
    push_ev(b + 10, EV_PRESS);
    push_ev(b + 20, EV_REL | EV_SHORT);
    push_lvl(b + 10, 1'b1);
    push_lvl(b + 20, 1'b0);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 10);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL bounce_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_long_hold;
    int b;
    start_seq(b);
    push_ev(b + 6, EV_PRESS);
    push_ev(b + 26, EV_LONG);
`ifdef BUTTON_REPEAT_EN
    push_ev(b + 34, EV_REP);
    push_ev(b + 42, EV_REP);
`endif
    push_ev(b + 46, EV_REL);
    push_lvl(b + 6, 1'b1);
    push_lvl(b + 46, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL long_hold_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_repeat;
    int b;
    start_seq(b);
    push_ev(b + 6, EV_PRESS);
    push_ev(b + 26, EV_LONG);
`ifdef BUTTON_REPEAT_EN
    push_ev(b + 34, EV_REP);
    push_ev(b + 42, EV_REP);
    push_ev(b + 50, EV_REP);
`endif
    push_ev(b + 56, EV_REL);
    push_lvl(b + 6, 1'b1);
    push_lvl(b + 56, 1'b0);
    drive(1'b0, 50);
    drive(1'b1, 16);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL repeat_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold;
    int b;
    int nb;
    logic [5:0] outs;
    start_seq(b);
    push_ev(b + 6, EV_PRESS);
    push_lvl(b + 6, 1'b1);
    push_lvl(b + 14, 1'b0);
    drive(1'b0, 15);
    nRst = 1'b0;
    #1;
    outs = {pressed, pressPulse, releasePulse, shortPress, longPress, repeatPulse};
    n_checks++;
    if (outs !== 6'b0) $display("FAIL reset_mid_outputs: got %b expected 000000", outs);
    else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    nRst = 1'b1;
    nb = edge_n + 1;
    push_ev(nb + 6, EV_PRESS);
    push_ev(nb + 26, EV_LONG);
`ifdef BUTTON_REPEAT_EN
    push_ev(nb + 34, EV_REP);
`endif
    push_ev(nb + 36, EV_REL);
    push_lvl(nb + 6, 1'b1);
    push_lvl(nb + 36, 1'b0);
    drive(1'b0, 30);
    drive(1'b1, 12);
    n_checks++;
    if (ev_q.size() != 0 || lvl_q.size() != 0)
      $display("FAIL reset_mid_drain: %0d/%0d entries left, expected 0", ev_q.size(), lvl_q.size());
    else n_pass++;
  endtask

  initial begin
    nRst = 1'b0;
    nBTN = 1'b1;
    test_reset;
    test_clean_press;
    test_min_press;
    test_glitch;
    test_bounce;
    test_long_hold;
    test_repeat;
    test_reset_mid_hold;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
